// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared widths, PC increments and fetch FSM state type
package pc_fetch_ctrl_pkg;
  localparam int PC_W = 48;
  localparam int LINE_W = 512;
  localparam int WORDS = 16;
  localparam int WORD_W = LINE_W / WORDS;
  localparam logic [PC_W-1:0] INC_FULL = 48'd64;
  localparam logic [PC_W-1:0] INC_CUT = 48'd60;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DELIVER} state_e;
endpackage

// File: rtl/pc_line_align.sv
// pc_line_align: drops word 0 of a fetched line when the fetch PC sits in its upper half
//   line/odd in: raw 16-word line and fetch_pc[2]; inst/cut out: aligned slots and 15-slot flag
module pc_line_align
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic              odd,
  output logic [LINE_W-1:0] inst,
  output logic              cut
);
  always_comb begin
    inst = odd ? {{WORD_W{1'b0}}, line[LINE_W-1:WORD_W]} : line;
    cut = odd;
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: sequential instruction-line fetcher with redirect and pending-fetch handling
//   in : clock, reset_n, redirect_valid/target, fetch_inst, pc_index_ready, pc_operation_done, pc_read_data
//   out: pc_index_valid/pc_index (arbiter request), ib_* delivery, cut_first_32_bit, can_fetch_inst, clear_ibuffer
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 48'h0000_8000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_target,
  input  logic              fetch_inst,
  output logic              pc_index_valid,
  output logic [PC_W-1:0]   pc_index,
  input  logic              pc_index_ready,
  input  logic              pc_operation_done,
  input  logic [LINE_W-1:0] pc_read_data,
  output logic              ib_operation_done,
  output logic [LINE_W-1:0] ib_read_inst,
  output logic [PC_W-1:0]   ib_pc,
  output logic              cut_first_32_bit,
  output logic              can_fetch_inst,
  output logic              clear_ibuffer
);
  state_e state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, ib_pc_q, ib_pc_d;
  logic [LINE_W-1:0] inst_q, inst_d, aligned;
  logic pending_q, pending_d, discard_q, discard_d, clear_q, clear_d, cut_q, cut_d, cut_a;
  logic hs, capture;
  pc_line_align u_align (
    .line(pc_read_data),
    .odd (fetch_pc_q[2]),
    .inst(aligned),
    .cut (cut_a)
  );
  assign hs = state_q == REQ && pc_index_ready;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    pending_d = pending_q || (fetch_inst && state_q != IDLE);
    discard_d = discard_q;
    clear_d = redirect_valid;
    capture = 1'b0;
    case (state_q)
      IDLE: if (fetch_inst || pending_q) begin
        state_d = REQ;
        pending_d = 1'b0;
      end
      REQ: state_d = hs ? WAIT : REQ;
      WAIT: if (pc_operation_done) begin
        state_d = discard_q ? REQ : DELIVER;
        capture = !discard_q;
        discard_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (capture) fetch_pc_d = fetch_pc_q + (cut_a ? INC_CUT : INC_FULL);
    // A redirect overrides everything: in-flight data is either dropped now or marked for discard.
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      pending_d = 1'b0;
      capture = 1'b0;
      case (state_q)
        REQ: begin
          state_d = hs ? WAIT : REQ;
          discard_d = hs;
        end
        WAIT: begin
          state_d = pc_operation_done ? REQ : WAIT;
          discard_d = !pc_operation_done;
        end
        default: state_d = REQ;
      endcase
    end
    inst_d = capture ? aligned : inst_q;
    cut_d = capture ? cut_a : cut_q;
    ib_pc_d = capture ? fetch_pc_q : ib_pc_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      pending_q <= 1'b1;
      discard_q <= 1'b0;
      clear_q <= 1'b0;
      inst_q <= '0;
      cut_q <= 1'b0;
      ib_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      clear_q <= clear_d;
      inst_q <= inst_d;
      cut_q <= cut_d;
      ib_pc_q <= ib_pc_d;
    end
  end
  assign pc_index_valid = state_q == REQ;
  assign pc_index = pc_index_valid ? {fetch_pc_q[PC_W-1:3], 3'b000} : '0;
  assign ib_operation_done = state_q == DELIVER && !redirect_valid;
  assign ib_read_inst = inst_q;
  assign ib_pc = ib_pc_q;
  assign cut_first_32_bit = cut_q;
  assign can_fetch_inst = state_q == IDLE && !pending_q;
  assign clear_ibuffer = clear_q;
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 48'h0000_8000_0000, giving the first fetch PC after reset.
REQ-002 The block SHALL have these ports:
- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  one-cycle pulse requesting a fetch-stream restart.
- redirect_target  in  48  new fetch PC, 4-byte aligned.
- fetch_inst  in  1  pulse from the ibuffer requesting the next 16-word block.
- pc_index_valid  out  1  read request to the arbiter.
- pc_index  out  48  request address, 8-byte aligned.
- pc_index_ready  in  1  arbiter accepts the request in a cycle where valid and ready are both 1.
- pc_operation_done  in  1  one-cycle pulse; read data is valid.
- pc_read_data  in  512  16 x 32-bit words, word 0 at pc_index.
- ib_operation_done  out  1  one-cycle delivery pulse to the ibuffer.
- ib_read_inst  out  512  delivered words, slot i = instruction at ib_pc + 4*i.
- ib_pc  out  48  PC of slot 0.
- cut_first_32_bit  out  1  delivery holds 15 valid slots (0..14).
- can_fetch_inst  out  1  block is IDLE and can accept fetch_inst.
- clear_ibuffer  out  1  one-cycle flush pulse to the ibuffer.

Function
REQ-003 State machine SHALL have 4 states: IDLE, REQ, WAIT, DELIVER.
REQ-004 IDLE->REQ SHALL occur on fetch_inst, or when a pending-fetch flag is set.
REQ-005 In REQ, pc_index_valid SHALL be 1 and pc_index = {fetch_pc[47:3],3'b0}, held stable until handshake.
REQ-006 REQ->WAIT SHALL occur on the handshake cycle.
REQ-007 WAIT->DELIVER SHALL occur on pc_operation_done; data SHALL be registered that same edge.
REQ-008 DELIVER SHALL last exactly 1 cycle with ib_operation_done=1, then go to IDLE.
REQ-009 Delivery latency SHALL be 1 cycle: ib_operation_done is asserted the cycle after pc_operation_done.
REQ-010 If fetch_pc[2]=0, the block SHALL deliver ib_read_inst=pc_read_data, cut_first_32_bit=0, ib_pc=fetch_pc, and set fetch_pc+=64.
REQ-011 If fetch_pc[2]=1, the block SHALL shift data right 32 bits (slot i = word i+1, slot 15 = 0), set cut_first_32_bit=1 and ib_pc=fetch_pc, and set fetch_pc+=60.
REQ-012 fetch_pc arithmetic SHALL be 48-bit modulo 2^48 (wraps silently).
REQ-013 A fetch_inst pulse arriving outside IDLE SHALL set the pending flag (saturating at one); the flag SHALL be cleared on IDLE->REQ.
REQ-014 can_fetch_inst SHALL be 1 only in IDLE with the pending flag clear.
REQ-015 On redirect_valid, the block SHALL set fetch_pc=redirect_target, pulse clear_ibuffer the next cycle, and clear the pending flag.
REQ-016 Redirect in IDLE or DELIVER SHALL go to REQ with the new PC, and any DELIVER pulse that cycle SHALL be suppressed.
REQ-017 Redirect in REQ SHALL keep valid asserted and stay in REQ, switching the address only if no handshake occurs that cycle; if the handshake does occur that cycle, the block SHALL treat it as a redirect in WAIT.
REQ-018 Redirect in WAIT SHALL set a discard flag; the next pc_operation_done SHALL be dropped (no delivery) and the block SHALL go to REQ with the new PC.
REQ-019 Redirect on the same cycle as pc_operation_done in WAIT SHALL drop that data and go to REQ.
REQ-020 Redirect SHALL take priority over fetch_inst in the same cycle.
REQ-021 After reset, the block SHALL start one fetch automatically from RESET_PC, because the pending flag resets to 1.
REQ-022 pc_operation_done outside WAIT SHALL be ignored.

Reset
REQ-023 On reset_n low, the block SHALL asynchronously enter IDLE with fetch_pc=RESET_PC, pending=1, discard=0, and all outputs 0 except ib_pc=RESET_PC.
REQ-024 Reset mid-transaction SHALL abandon it, and the block SHALL issue no delivery for the abandoned request.

Structure
REQ-025 A shared package SHALL hold the state enum, PC width 48, line width 512, words-per-line 16, and the 64/60 increments.
REQ-026 One sub-module SHALL exist: pc_line_align, a combinational 32-bit shifter producing ib_read_inst and cut_first_32_bit.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset release, ready=1, done 3 cycles later with data D -> request at 0x8000_0000; delivery D, ib_pc=0x8000_0000, cut=0; next fetch at 0x8000_0040.
- Redirect to 0x1004, then fetch -> pc_index=0x1000; slot0=word1, slot15=0, cut=1, ib_pc=0x1004; next pc_index=0x1040.
- Redirect to 0x2000 while in WAIT -> clear_ibuffer pulse; the following done produces no ib_operation_done; new request at 0x2000.
- Two fetch_inst pulses during WAIT -> exactly one extra request after delivery; can_fetch_inst=0 until it completes.
- pc_index_ready held 0 for 5 cycles -> pc_index_valid and pc_index stable throughout; a redirect in cycle 3 changes the address to the target.
- fetch_pc=0xFFFF_FFFF_FFC0 delivered -> next fetch_pc wraps to 0x0.
